// File: rtl/load_extend_pipe_pkg.sv
// load_extend_pipe shared package: size codes and size-to-bytes helper.
// Imported by the interface users, the top and the ext_unit sub-module.
package load_extend_pipe_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  function automatic logic [3:0] size_bytes(
    input logic [1:0] sz
  );
    logic [3:0] nb;
    nb = 4'd1;
    unique case (1'b1)
      (sz == SZ_BYTE):  nb = 4'd1;
      (sz == SZ_HALF):  nb = 4'd2;
      (sz == SZ_WORD):  nb = 4'd4;
      (sz == SZ_DWORD): nb = 4'd8;
      default:          nb = 4'd1;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/load_extend_pipe_if.sv
// load_extend_pipe bus: input beat (iValid/oReady, data, offset, size,
// sext) and output beat (oValid/iReady, oData, oErr); slave = the pipe.
interface load_extend_pipe_if #(
  parameter int DATA_W = 32
);
  localparam int OFF_W = $clog2(DATA_W/8);

  logic              iValid;
  logic              oReady;
  logic [DATA_W-1:0] iData;
  logic [OFF_W-1:0]  iOff;
  logic [1:0]        iSize;
  logic              iSext;
  logic              oValid;
  logic              iReady;
  logic [DATA_W-1:0] oData;
  logic              oErr;

  modport slave (
    input  iValid, iData, iOff, iSize, iSext, iReady,
    output oReady, oValid, oData, oErr
  );

  modport master (
    output iValid, iData, iOff, iSize, iSext, iReady,
    input  oReady, oValid, oData, oErr
  );

endinterface

// File: rtl/load_extend_pipe_ext_unit.sv
// ext_unit: combinational sign/zero extender of a low-aligned lane.
// lane_i/size_i/sext_i in, data_o (DATA_W) out; lanes >= DATA_W pass through.
module ext_unit
  import load_extend_pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] lane_i,
  input  logic [1:0]        size_i,
  input  logic              sext_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int IDX_W = $clog2(DATA_W);

  logic [6:0]        nbits;
  logic [DATA_W-1:0] hi_mask;
  logic              sbit;

  always_comb begin
    nbits   = {size_bytes(size_i), 3'b000};
    hi_mask = '0;
    sbit    = 1'b0;
    data_o  = lane_i;
    if (int'(nbits) < DATA_W) begin
      hi_mask = {DATA_W{1'b1}} << nbits;
      sbit    = lane_i[IDX_W'(nbits - 7'd1)];
      data_o  = (lane_i & ~hi_mask)
              | (hi_mask & {DATA_W{sext_i & sbit}});
    end
  end

endmodule

// File: rtl/load_extend_pipe.sv
// load_extend_pipe: 2-stage valid/ready load aligner + extender.
// iClk/iRst_n, bus (slave modport); LOAD_EXT_TRI_EN adds iBusEn/oTriData.
module load_extend_pipe
  import load_extend_pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              iClk,
  input  logic              iRst_n,
`ifdef LOAD_EXT_TRI_EN
  input  logic              iBusEn,
  output wire [DATA_W-1:0]  oTriData,
`endif
  load_extend_pipe_if.slave bus
);

  localparam int OFF_W = $clog2(DATA_W/8);

  logic              v1_q, v1_d;
  logic              v2_q, v2_d;
  logic [DATA_W-1:0] lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              oerr_q, oerr_d;

  logic              s1_ld;
  logic              s2_ld;
  logic [DATA_W-1:0] shifted;
  logic [3:0]        sb;
  logic              in_err;
  logic [DATA_W-1:0] ext_data;

  ext_unit #(
    .DATA_W (DATA_W)
  ) u_ext (
    .lane_i (lane_q),
    .size_i (size_q),
    .sext_i (sext_q),
    .data_o (ext_data)
  );

  always_comb begin
    s2_ld   = !v2_q || bus.iReady;
    s1_ld   = !v1_q || s2_ld;
    shifted = bus.iData >> {bus.iOff, 3'b000};
    sb      = size_bytes(bus.iSize);
    // offset must be a multiple of the access size
    in_err  = (|(bus.iOff & OFF_W'(sb - 4'd1)))
           || ((bus.iSize == SZ_DWORD) && (DATA_W == 32));

    v1_d   = v1_q;
    lane_d = lane_q;
    size_d = size_q;
    sext_d = sext_q;
    err_d  = err_q;
    if (s1_ld) begin
      v1_d = bus.iValid;
      if (bus.iValid) begin
        lane_d = shifted;
        size_d = bus.iSize;
        sext_d = bus.iSext;
        err_d  = in_err;
      end
    end

    v2_d   = v2_q;
    data_d = data_q;
    oerr_d = oerr_q;
    if (s2_ld) begin
      v2_d = v1_q;
      if (v1_q) begin
        data_d = err_q ? '0 : ext_data;
        oerr_d = err_q;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      lane_q <= '0;
      size_q <= SZ_BYTE;
      sext_q <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
      oerr_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      lane_q <= lane_d;
      size_q <= size_d;
      sext_q <= sext_d;
      err_q  <= err_d;
      data_q <= data_d;
      oerr_q <= oerr_d;
    end
  end

  assign bus.oReady = s1_ld;
  assign bus.oValid = v2_q;
  assign bus.oData  = data_q;
  assign bus.oErr   = oerr_q;

`ifdef LOAD_EXT_TRI_EN
  assign oTriData = (v2_q && iBusEn) ? data_q
                                     : {DATA_W{1'bz}};
`endif

endmodule

// File: tb/tb_load_extend_pipe.sv
// tb_load_extend_pipe: directed + random checks of load_extend_pipe
// (32- and 64-bit instances) against a behavioural queue model.
module tb_load_extend_pipe;
  import load_extend_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_extend_pipe_if #(.DATA_W(32)) b32 ();
  load_extend_pipe_if #(.DATA_W(64)) b64 ();

`ifdef LOAD_EXT_TRI_EN
  logic        be32 = 1'b0;
  logic        be64 = 1'b0;
  wire  [31:0] t32;
  wire  [63:0] t64;
`endif

  load_extend_pipe #(.DATA_W(32)) u32 (
    .iClk     (clk),
    .iRst_n   (rst_n),
`ifdef LOAD_EXT_TRI_EN
    .iBusEn   (be32),
    .oTriData (t32),
`endif
    .bus      (b32)
  );

  load_extend_pipe #(.DATA_W(64)) u64 (
    .iClk     (clk),
    .iRst_n   (rst_n),
`ifdef LOAD_EXT_TRI_EN
    .iBusEn   (be64),
    .oTriData (t64),
`endif
    .bus      (b64)
  );

  int total = 0;
  int passed = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] d;
    logic        e;
    int          t;
  } exp_t;

  exp_t        q[$];
  logic        stall_prev = 1'b0;
  logic [31:0] hold_d = '0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  // Reference: pick lane by byte offset, extend by size, flag misalignment.
  function automatic void model(input int dw,
                                input logic [63:0] data,
                                input int off, input int size,
                                input logic sext,
                                output logic [63:0] res,
                                output logic err);
    int nb;
    logic [63:0] m, lane, dm;
    nb  = 1 << size;
    err = ((off % nb) != 0) || (nb * 8 > dw);
    res = '0;
    if (!err) begin
      m    = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
      lane = (data >> (8 * off)) & m;
      if (sext && lane[8 * nb - 1]) lane = lane | ~m;
      dm   = (dw == 64) ? '1 : 64'hFFFF_FFFF;
      res  = lane & dm;
    end
  endfunction

  // One cycle on the 32-bit pipe, checked against the queue model.
  task automatic step(input logic v, input logic [31:0] d,
                      input int off, input int size,
                      input logic sx, input logic rdy);
    logic ov, er, acc, ret, ee;
    logic [63:0] ed;
    b32.iValid = v;
    b32.iData  = d;
    b32.iOff   = off[1:0];
    b32.iSize  = size[1:0];
    b32.iSext  = sx;
    b32.iReady = rdy;
    #1;
    ov = (q.size() > 0) && (cyc - q[0].t >= 1);
    er = !((q.size() == 2) && !rdy);
    chk("oValid", 64'(b32.oValid), 64'(ov));
    chk("oReady", 64'(b32.oReady), 64'(er));
    if (ov) begin
      chk("oData", 64'(b32.oData), q[0].d);
      chk("oErr", 64'(b32.oErr), 64'(q[0].e));
    end
    if (stall_prev)
      chk("stall_hold", 64'(b32.oData), 64'(hold_d));
    stall_prev = ov && !rdy;
    hold_d = b32.oData;
    acc = v && er;
    ret = ov && rdy;
    model(32, 64'(d), off, size, sx, ed, ee);
    @(posedge clk);
    cyc++;
    if (ret) void'(q.pop_front());
    if (acc) q.push_back('{ed, ee, cyc});
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() > 0; i++)
      step(1'b0, '0, 0, 0, 1'b0, 1'b1);
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic beat32(input string tag,
                        input logic [31:0] d, input int off,
                        input int size, input logic sx,
                        input logic [31:0] xd, input logic xe);
    b32.iValid = 1'b1;
    b32.iData  = d;
    b32.iOff   = off[1:0];
    b32.iSize  = size[1:0];
    b32.iSext  = sx;
    b32.iReady = 1'b1;
    @(posedge clk); cyc++;
    @(negedge clk);
    b32.iValid = 1'b0;
    @(posedge clk); cyc++;
    @(negedge clk);
    chk({tag, "_v"}, 64'(b32.oValid), 64'd1);
    chk({tag, "_d"}, 64'(b32.oData), 64'(xd));
    chk({tag, "_e"}, 64'(b32.oErr), 64'(xe));
    @(posedge clk); cyc++;
    @(negedge clk);
  endtask

  task automatic beat64(input string tag,
                        input logic [63:0] d, input int off,
                        input int size, input logic sx,
                        input logic [63:0] xd, input logic xe);
    b64.iValid = 1'b1;
    b64.iData  = d;
    b64.iOff   = off[2:0];
    b64.iSize  = size[1:0];
    b64.iSext  = sx;
    b64.iReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b64.iValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_v"}, 64'(b64.oValid), 64'd1);
    chk({tag, "_d"}, b64.oData, xd);
    chk({tag, "_e"}, 64'(b64.oErr), 64'(xe));
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [31:0] W = 32'h8070_F0A5;

  initial begin
    int nacc;
    int lim;
    logic [63:0] rd, xd;
    logic xe;
    int ro, rs;
    logic rx;

    b32.iValid = 1'b0; b32.iData = '0; b32.iOff = '0;
    b32.iSize = '0; b32.iSext = 1'b0; b32.iReady = 1'b1;
    b64.iValid = 1'b0; b64.iData = '0; b64.iOff = '0;
    b64.iSize = '0; b64.iSext = 1'b0; b64.iReady = 1'b1;
    #1;
    chk("rst_oValid", 64'(b32.oValid), 64'd0);
    chk("rst_oData", 64'(b32.oData), 64'd0);
    chk("rst_oErr", 64'(b32.oErr), 64'd0);
    chk("rst_oReady", 64'(b32.oReady), 64'd1);
    chk("rst64_oValid", 64'(b64.oValid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    beat32("byte_sx", W, 0, 0, 1'b1, 32'hFFFF_FFA5, 1'b0);
    beat32("byte_zx", W, 0, 0, 1'b0, 32'h0000_00A5, 1'b0);
    beat32("half_sx", W, 2, 1, 1'b1, 32'hFFFF_8070, 1'b0);
    beat32("half_zx", W, 2, 1, 1'b0, 32'h0000_8070, 1'b0);
    beat32("half_mis", W, 1, 1, 1'b1, 32'h0, 1'b1);
    beat32("word_mis", W, 2, 2, 1'b1, 32'h0, 1'b1);
    beat32("dword32", W, 0, 3, 1'b0, 32'h0, 1'b1);
    beat32("top_byte", W, 3, 0, 1'b1, 32'hFFFF_FF80, 1'b0);
    beat32("word_ok", W, 0, 2, 1'b1, W, 1'b0);
    beat32("not_sticky", W, 1, 0, 1'b1, 32'hFFFF_FFF0, 1'b0);

    beat64("w64_sx", 64'h8000_0001_0000_0000, 4, 2, 1'b1,
           64'hFFFF_FFFF_8000_0001, 1'b0);
    beat64("dw64", 64'h8000_0001_0000_0000, 0, 3, 1'b1,
           64'h8000_0001_0000_0000, 1'b0);
    beat64("w64_mis", 64'h1234_5678_9ABC_DEF0, 2, 2, 1'b0,
           64'h0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      rd = {$urandom, $urandom};
      ro = int'($urandom_range(0, 7));
      rs = int'($urandom_range(0, 3));
      rx = 1'($urandom_range(0, 1));
      model(64, rd, ro, rs, rx, xd, xe);
      beat64("r64", rd, ro, rs, rx, xd, xe);
    end

    nacc = 0;
    lim = 0;
    while (nacc < 8 && lim < 40) begin
      logic r;
      r = (lim % 4 == 0) || (lim % 4 == 3);
      if (!((q.size() == 2) && !r)) nacc++;
      step(1'b1, $urandom, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), r);
      lim++;
    end
    chk("bp_accepted", 64'(nacc), 64'd8);
    drain();

    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    drain();

    step(1'b1, 32'h0000_00FF, 0, 0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0011, 0, 0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0022, 0, 0, 1'b1, 1'b0);
    chk("full_before_rst", 64'(q.size()), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_oValid", 64'(b32.oValid), 64'd0);
    chk("mrst_oData", 64'(b32.oData), 64'd0);
    chk("mrst_oReady", 64'(b32.oReady), 64'd1);
    q.delete();
    stall_prev = 1'b0;
    b32.iValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, W, 2, 1, 1'b1, 1'b1);
    step(1'b0, '0, 0, 0, 1'b0, 1'b1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
